// File: rtl/id_ex_stage_reg_if.sv
// ID/EX stage bus: decoded instruction from ID, registered copy toward EX, hazard/perf status back.
// Master drives the ID side and pipeline controls; slave is the stage register.
interface id_ex_stage_reg_if #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 4
);
    logic               id_valid_i;
    logic [XLEN-1:0]    id_pc_i;
    logic [4:0]         id_rs1_label_i;
    logic [4:0]         id_rs2_label_i;
    logic [4:0]         id_rd_label_i;
    logic [XLEN-1:0]    id_rs1_data_i;
    logic [XLEN-1:0]    id_rs2_data_i;
    logic [XLEN-1:0]    id_imm_i;
    logic [ALUOP_W-1:0] id_alu_op_i;
    logic               id_is_load_i;
    logic               id_mem_write_i;
    logic               id_reg_write_i;
    logic               mem_stall_i;
    logic               flush_i;

    logic               ex_valid_o;
    logic [XLEN-1:0]    ex_pc_o;
    logic [4:0]         ex_rs1_label_o;
    logic [4:0]         ex_rs2_label_o;
    logic [4:0]         ex_rd_label_o;
    logic [XLEN-1:0]    ex_rs1_data_o;
    logic [XLEN-1:0]    ex_rs2_data_o;
    logic [XLEN-1:0]    ex_imm_o;
    logic [ALUOP_W-1:0] ex_alu_op_o;
    logic               ex_is_load_o;
    logic               ex_mem_write_o;
    logic               ex_reg_write_o;
    logic               stall_o;
    logic [31:0]        load_use_cnt_o;
    logic [31:0]        flush_cnt_o;

    modport master (
        output id_valid_i, id_pc_i, id_rs1_label_i, id_rs2_label_i, id_rd_label_i,
               id_rs1_data_i, id_rs2_data_i, id_imm_i, id_alu_op_i,
               id_is_load_i, id_mem_write_i, id_reg_write_i, mem_stall_i, flush_i,
        input  ex_valid_o, ex_pc_o, ex_rs1_label_o, ex_rs2_label_o, ex_rd_label_o,
               ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_alu_op_o,
               ex_is_load_o, ex_mem_write_o, ex_reg_write_o,
               stall_o, load_use_cnt_o, flush_cnt_o
    );

    modport slave (
        input  id_valid_i, id_pc_i, id_rs1_label_i, id_rs2_label_i, id_rd_label_i,
               id_rs1_data_i, id_rs2_data_i, id_imm_i, id_alu_op_i,
               id_is_load_i, id_mem_write_i, id_reg_write_i, mem_stall_i, flush_i,
        output ex_valid_o, ex_pc_o, ex_rs1_label_o, ex_rs2_label_o, ex_rd_label_o,
               ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_alu_op_o,
               ex_is_load_o, ex_mem_write_o, ex_reg_write_o,
               stall_o, load_use_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion and flush; HAZARD_PERF_CNT_EN adds event counters.
// Latency: one edge from id_* to ex_*. Backpressure: stall_o (comb) holds PC and IF/ID; mem_stall_i freezes the stage.
module id_ex_stage_reg #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    id_ex_stage_reg_if.slave bus
);
    typedef struct packed {
        logic               valid;
        logic [XLEN-1:0]    pc;
        logic [4:0]         rs1_label;
        logic [4:0]         rs2_label;
        logic [4:0]         rd_label;
        logic [XLEN-1:0]    rs1_data;
        logic [XLEN-1:0]    rs2_data;
        logic [XLEN-1:0]    imm;
        logic [ALUOP_W-1:0] alu_op;
        logic               is_load;
        logic               mem_write;
        logic               reg_write;
    } stage_t;

    stage_t ex_q;
    stage_t id_d;
    logic   load_use;

    // An invalid ID slot is captured as an all-zero bubble.
    always_comb begin
        id_d = '0;
        if (bus.id_valid_i) begin
            id_d.valid     = 1'b1;
            id_d.pc        = bus.id_pc_i;
            id_d.rs1_label = bus.id_rs1_label_i;
            id_d.rs2_label = bus.id_rs2_label_i;
            id_d.rd_label  = bus.id_rd_label_i;
            id_d.rs1_data  = bus.id_rs1_data_i;
            id_d.rs2_data  = bus.id_rs2_data_i;
            id_d.imm       = bus.id_imm_i;
            id_d.alu_op    = bus.id_alu_op_i;
            id_d.is_load   = bus.id_is_load_i;
            id_d.mem_write = bus.id_mem_write_i;
            id_d.reg_write = bus.id_reg_write_i;
        end
    end

    assign load_use = ex_q.valid && ex_q.is_load && (ex_q.rd_label != 5'd0) && bus.id_valid_i &&
                      ((bus.id_rs1_label_i == ex_q.rd_label) || (bus.id_rs2_label_i == ex_q.rd_label));

    assign bus.stall_o = bus.mem_stall_i || (load_use && !bus.flush_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_q <= '0;
        end else if (!bus.mem_stall_i) begin
            if (bus.flush_i || load_use) begin
                ex_q <= '0;
            end else begin
                ex_q <= id_d;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] load_use_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            load_use_cnt_q <= '0;
            flush_cnt_q    <= '0;
        end else if (!bus.mem_stall_i) begin
            if (bus.flush_i) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end else if (load_use) begin
                load_use_cnt_q <= load_use_cnt_q + 32'd1;
            end
        end
    end

    assign bus.load_use_cnt_o = load_use_cnt_q;
    assign bus.flush_cnt_o    = flush_cnt_q;
`else
    assign bus.load_use_cnt_o = 32'd0;
    assign bus.flush_cnt_o    = 32'd0;
`endif

    assign bus.ex_valid_o     = ex_q.valid;
    assign bus.ex_pc_o        = ex_q.pc;
    assign bus.ex_rs1_label_o = ex_q.rs1_label;
    assign bus.ex_rs2_label_o = ex_q.rs2_label;
    assign bus.ex_rd_label_o  = ex_q.rd_label;
    assign bus.ex_rs1_data_o  = ex_q.rs1_data;
    assign bus.ex_rs2_data_o  = ex_q.rs2_data;
    assign bus.ex_imm_o       = ex_q.imm;
    assign bus.ex_alu_op_o    = ex_q.alu_op;
    assign bus.ex_is_load_o   = ex_q.is_load;
    assign bus.ex_mem_write_o = ex_q.mem_write;
    assign bus.ex_reg_write_o = ex_q.reg_write;
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: directed hazard scenarios followed by constrained-random traffic.
module tb_id_ex_stage_reg;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [3:0]  op;
        logic        ld;
        logic        mw;
        logic        rw;
    } ins_t;

    typedef struct packed {
        logic        stall;
        ins_t        ex;
        logic [31:0] lcnt;
        logic [31:0] fcnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t q[$];

    ins_t        m_ex = '0;
    logic [31:0] m_lcnt = 0;
    logic [31:0] m_fcnt = 0;
    logic        last_stall = 1'b0;

    id_ex_stage_reg_if #(.XLEN(32), .ALUOP_W(4)) bus ();
    id_ex_stage_reg #(.XLEN(32), .ALUOP_W(4)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic ins_t mk(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm,
                                input logic ld);
        ins_t s;
        s       = '0;
        s.valid = v;
        s.pc    = pc;
        s.rs1   = rs1;
        s.rs2   = rs2;
        s.rd    = rd;
        s.d1    = pc ^ 32'hA5A5_0000;
        s.d2    = pc + 32'd17;
        s.imm   = imm;
        s.op    = pc[3:0];
        s.ld    = ld;
        s.rw    = 1'b1;
        return s;
    endfunction

    task automatic drive(input ins_t s, input logic ms, input logic fl);
        bus.id_valid_i     = s.valid;
        bus.id_pc_i        = s.pc;
        bus.id_rs1_label_i = s.rs1;
        bus.id_rs2_label_i = s.rs2;
        bus.id_rd_label_i  = s.rd;
        bus.id_rs1_data_i  = s.d1;
        bus.id_rs2_data_i  = s.d2;
        bus.id_imm_i       = s.imm;
        bus.id_alu_op_i    = s.op;
        bus.id_is_load_i   = s.ld;
        bus.id_mem_write_i = s.mw;
        bus.id_reg_write_i = s.rw;
        bus.mem_stall_i    = ms;
        bus.flush_i        = fl;
    endtask

    // Reference: what EX should hold after this edge, stated directly from the hazard rules.
    task automatic step(input ins_t s, input logic ms, input logic fl);
        exp_t e;
        logic dep;
        @(negedge clk);
        drive(s, ms, fl);
        dep = m_ex.valid && m_ex.ld && (m_ex.rd != 0) && s.valid &&
              (s.rs1 == m_ex.rd || s.rs2 == m_ex.rd);
        e.stall = ms || (dep && !fl);
        if (!ms) begin
            if (fl) begin
                m_ex   = '0;
                m_fcnt = m_fcnt + 1;
            end else if (dep) begin
                m_ex   = '0;
                m_lcnt = m_lcnt + 1;
            end else begin
                m_ex = s.valid ? s : '0;
            end
        end
        e.ex = m_ex;
`ifdef HAZARD_PERF_CNT_EN
        e.lcnt = m_lcnt;
        e.fcnt = m_fcnt;
`else
        e.lcnt = 0;
        e.fcnt = 0;
`endif
        q.push_back(e);
        last_stall = e.stall;
    endtask

    // Monitor: stall_o checked mid-cycle, EX state just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() != 0) begin
                e = q[0];
                chk("stall_o", {31'd0, bus.stall_o}, {31'd0, e.stall});
                @(posedge clk);
                #1;
                chk("ex_valid", {31'd0, bus.ex_valid_o}, {31'd0, e.ex.valid});
                chk("ex_pc", bus.ex_pc_o, e.ex.pc);
                chk("ex_rs1_label", {27'd0, bus.ex_rs1_label_o}, {27'd0, e.ex.rs1});
                chk("ex_rs2_label", {27'd0, bus.ex_rs2_label_o}, {27'd0, e.ex.rs2});
                chk("ex_rd_label", {27'd0, bus.ex_rd_label_o}, {27'd0, e.ex.rd});
                chk("ex_rs1_data", bus.ex_rs1_data_o, e.ex.d1);
                chk("ex_rs2_data", bus.ex_rs2_data_o, e.ex.d2);
                chk("ex_imm", bus.ex_imm_o, e.ex.imm);
                chk("ex_alu_op", {28'd0, bus.ex_alu_op_o}, {28'd0, e.ex.op});
                chk("ex_ctrl", {29'd0, bus.ex_is_load_o, bus.ex_mem_write_o, bus.ex_reg_write_o},
                    {29'd0, e.ex.ld, e.ex.mw, e.ex.rw});
                chk("load_use_cnt", bus.load_use_cnt_o, e.lcnt);
                chk("flush_cnt", bus.flush_cnt_o, e.fcnt);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        ins_t cur;
        logic ms, fl, last_ms, last_fl;
        int   n;

        // Reset with a valid load and mem stall presented: outputs must stay clear.
        drive(mk(1'b1, 32'h100, 5'd0, 5'd0, 5'd5, 32'h7FF, 1'b1), 1'b1, 1'b0);
        #12;
        chk("rst_ex_valid", {31'd0, bus.ex_valid_o}, 32'd0);
        chk("rst_ex_pc", bus.ex_pc_o, 32'd0);
        chk("rst_ex_rd", {27'd0, bus.ex_rd_label_o}, 32'd0);
        chk("rst_ex_imm", bus.ex_imm_o, 32'd0);
        chk("rst_cnt", bus.load_use_cnt_o | bus.flush_cnt_o, 32'd0);
        chk("rst_stall_ms1", {31'd0, bus.stall_o}, 32'd1);
        bus.mem_stall_i = 1'b0;
        #1;
        chk("rst_stall_ms0", {31'd0, bus.stall_o}, 32'd0);
        @(negedge clk);
        drive('0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Capture after reset, then load-use on rs2.
        step(mk(1'b1, 32'h100, 5'd0, 5'd0, 5'd5, 32'h7FF, 1'b0), 1'b0, 1'b0);
        step(mk(1'b1, 32'h104, 5'd1, 5'd2, 5'd3, 32'h4, 1'b1), 1'b0, 1'b0);
        cur = mk(1'b1, 32'h108, 5'd6, 5'd3, 5'd4, 32'h8, 1'b0);
        step(cur, 1'b0, 1'b0);
        step(cur, 1'b0, 1'b0);
        // Load to x0 never stalls; non-load producer never stalls.
        step(mk(1'b1, 32'h10C, 5'd1, 5'd0, 5'd0, 32'h0, 1'b1), 1'b0, 1'b0);
        step(mk(1'b1, 32'h110, 5'd0, 5'd0, 5'd3, 32'h1, 1'b0), 1'b0, 1'b0);
        step(mk(1'b1, 32'h114, 5'd3, 5'd1, 5'd3, 32'h2, 1'b1), 1'b0, 1'b0);
        // Flush wins over a pending load-use.
        step(mk(1'b1, 32'h118, 5'd3, 5'd0, 5'd7, 32'h3, 1'b0), 1'b0, 1'b1);
        // Memory stall with flush held, then the flush lands.
        step(mk(1'b1, 32'h11C, 5'd1, 5'd1, 5'd2, 32'h5, 1'b1), 1'b0, 1'b0);
        cur = mk(1'b1, 32'h120, 5'd2, 5'd2, 5'd6, 32'h6, 1'b0);
        for (int i = 0; i < 3; i++) step(cur, 1'b1, 1'b1);
        step(cur, 1'b0, 1'b1);

        // Random traffic: small label space to provoke hazards, ID held while stalled.
        last_ms = 1'b0;
        last_fl = 1'b0;
        cur = '0;
        for (int i = 0; i < 400; i++) begin
            if (!last_stall) begin
                cur = mk($urandom_range(7) != 0, $urandom, 5'($urandom_range(3)), 5'($urandom_range(3)),
                         5'($urandom_range(3)), $urandom, 1'($urandom_range(1)));
                cur.mw = 1'($urandom_range(1));
                cur.rw = 1'($urandom_range(1));
            end
            ms = ($urandom_range(6) == 0);
            fl = (last_ms && last_fl) ? 1'b1 : ($urandom_range(7) == 0);
            step(cur, ms, fl);
            last_ms = ms;
            last_fl = fl;
        end

        // Park a valid load in EX, then reset asynchronously between edges.
        step('0, 1'b0, 1'b0);
        step(mk(1'b1, 32'h200, 5'd1, 5'd2, 5'd9, 32'h10, 1'b1), 1'b0, 1'b0);
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        chk("scoreboard_drain", q.size(), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_ex_valid", {31'd0, bus.ex_valid_o}, 32'd0);
        chk("arst_ex_load", {31'd0, bus.ex_is_load_o}, 32'd0);
        chk("arst_ex_rd", {27'd0, bus.ex_rd_label_o}, 32'd0);
        chk("arst_ex_pc", bus.ex_pc_o, 32'd0);
        chk("arst_cnt", bus.load_use_cnt_o | bus.flush_cnt_o, 32'd0);
        chk("arst_stall", {31'd0, bus.stall_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
